// File: rtl/clk_div_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : clk_div_pkg
//  Description : Shared types and helpers for the programmable clock divider.
//                - div_state_t : controller state encoding (IDLE/RUN/STOP)
//                - CNT_W_DEFAULT : default half-period counter width
//                - clamp_half() : maps a half-period of 0 to 1
//  Revision    : 1.0 - initial release
// ============================================================================
package clk_div_pkg;

  localparam int unsigned CNT_W_DEFAULT = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_STOP = 2'd2
  } div_state_t;

  // A half-period of zero has no meaning; treat it as the fastest ratio.
  function automatic int unsigned clamp_half(input int unsigned half);
    return (half == 0) ? 1 : half;
  endfunction

endpackage : clk_div_pkg
`default_nettype wire

// File: rtl/clk_div_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : clk_div_ctrl_if
//  Description : Control/status bundle of the clock-divider controller.
//  Signals     : run_en    - level request to run the divider
//                cfg_valid - new half-period offered
//                cfg_half  - offered half-period (0 is stored as 1)
//                cfg_ready - controller can accept a config
//                clk_d     - divided clock level
//                tick_rise - pulse in first cycle clk_d reads 1
//                tick_fall - pulse in first cycle clk_d reads 0 after high
//                cur_half  - half-period currently in effect
//                running   - divider in RUN or STOP
//  Modports    : master - register/control side, slave - the controller
//  Revision    : 1.0 - initial release
// ============================================================================
interface clk_div_ctrl_if
  import clk_div_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEFAULT
);

  logic             run_en;
  logic             cfg_valid;
  logic [CNT_W-1:0] cfg_half;
  logic             cfg_ready;
  logic             clk_d;
  logic             tick_rise;
  logic             tick_fall;
  logic [CNT_W-1:0] cur_half;
  logic             running;

  modport master (
    output run_en, cfg_valid, cfg_half,
    input  cfg_ready, clk_d, tick_rise, tick_fall, cur_half, running
  );

  modport slave (
    input  run_en, cfg_valid, cfg_half,
    output cfg_ready, clk_d, tick_rise, tick_fall, cur_half, running
  );

endinterface : clk_div_ctrl_if
`default_nettype wire

// File: rtl/clk_div_counter.sv
`default_nettype none
// ============================================================================
//  Module      : clk_div_counter
//  Description : Half-period counter. Counts 0..half-1 while inc is high and
//                flags wrap when the count sits at half-1; the following
//                increment returns it to 0. clr forces the count to 0 and
//                takes priority over inc.
//  Ports       : clk  - system clock
//                rst  - asynchronous reset, active low
//                clr  - synchronous clear to 0
//                inc  - advance the count this cycle
//                half - half-period H (always >= 1)
//                wrap - count == H-1 (combinational)
//  Revision    : 1.0 - initial release
// ============================================================================
module clk_div_counter
  import clk_div_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  input  logic [CNT_W-1:0] half,
  output logic             wrap
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  logic [CNT_W-1:0] count;

  // half >= 1 is guaranteed upstream, so half-1 never underflows.
  assign wrap = (count == (half - ONE));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc) begin
      count <= wrap ? '0 : (count + ONE);
    end
  end

endmodule : clk_div_counter
`default_nettype wire

// File: rtl/clk_div_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : clk_div_ctrl
//  Description : Programmable clock-divider controller. Produces a divided
//                clock level clk_d (period 2*H) with aligned rise/fall ticks.
//                H is reconfigured over a valid/ready handshake; while the
//                divider runs, a new H is parked and only loaded at a falling
//                toggle, and a stop never cuts a high phase short, so clk_d
//                never produces a runt pulse.
//  Ports       : clk - system clock (rising edge)
//                rst - asynchronous reset, active low
//                bus - clk_div_ctrl_if.slave control/status bundle
//  Revision    : 1.0 - initial release
// ============================================================================
module clk_div_ctrl
  import clk_div_pkg::*;
#(
  parameter int unsigned CNT_W        = CNT_W_DEFAULT,
  parameter int unsigned DEFAULT_HALF = 2
) (
  input  logic           clk,
  input  logic           rst,
  clk_div_ctrl_if.slave  bus
);

  localparam logic [CNT_W-1:0] HALF_RST = CNT_W'(clamp_half(DEFAULT_HALF));

  // Registered state
  div_state_t       state;
  logic             clk_d;
  logic             tick_rise;
  logic             tick_fall;
  logic [CNT_W-1:0] cur_half;
  logic             pend;
  logic [CNT_W-1:0] pend_half;
  logic             cfg_ready;
  logic             running;

  // Next-state values
  div_state_t       state_nxt;
  logic             clk_d_nxt;
  logic             tick_rise_nxt;
  logic             tick_fall_nxt;
  logic [CNT_W-1:0] cur_half_nxt;
  logic             pend_nxt;
  logic [CNT_W-1:0] pend_half_nxt;

  // Datapath helpers
  logic             wrap;
  logic             active;
  logic             at_wrap;
  logic             fall_evt;
  logic             accept;
  logic             cnt_clr;
  logic [CNT_W-1:0] cfg_clamped;

  assign active      = (state != ST_IDLE);
  assign at_wrap     = active && wrap;
  assign fall_evt    = at_wrap && clk_d;
  // cfg_ready is exactly !pend, so accept can be derived from the flag itself.
  assign accept      = bus.cfg_valid && !pend;
  assign cfg_clamped = CNT_W'(clamp_half(32'(bus.cfg_half)));
  // Whenever the controller lands in IDLE the counter must read 0.
  assign cnt_clr     = (state_nxt == ST_IDLE);

  clk_div_counter #(
    .CNT_W (CNT_W)
  ) u_counter (
    .clk  (clk),
    .rst  (rst),
    .clr  (cnt_clr),
    .inc  (active),
    .half (cur_half),
    .wrap (wrap)
  );

  // --------------------------------------------------------------------------
  // Next-state / output logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_nxt     = state;
    clk_d_nxt     = clk_d;
    tick_rise_nxt = 1'b0;
    tick_fall_nxt = 1'b0;
    cur_half_nxt  = cur_half;
    pend_nxt      = pend;
    pend_half_nxt = pend_half;

    unique case (state)
      ST_IDLE: begin
        if (bus.run_en) begin
          state_nxt = ST_RUN;
        end
      end

      ST_RUN: begin
        if (!bus.run_en && !clk_d) begin
          // Low phase: stopping here cannot shorten a high pulse.
          state_nxt = ST_IDLE;
        end else begin
          if (at_wrap) begin
            clk_d_nxt     = !clk_d;
            tick_rise_nxt = !clk_d;
            tick_fall_nxt = clk_d;
          end
          if (!bus.run_en) begin
            // clk_d is high here; finish the high phase in STOP unless it
            // ends this very cycle.
            state_nxt = at_wrap ? ST_IDLE : ST_STOP;
          end
        end
      end

      ST_STOP: begin
        // clk_d is always high in STOP, so a wrap is the falling toggle.
        if (at_wrap) begin
          clk_d_nxt     = 1'b0;
          tick_fall_nxt = 1'b1;
        end
        if (bus.run_en) begin
          state_nxt = ST_RUN;
        end else if (at_wrap) begin
          state_nxt = ST_IDLE;
        end
      end

      default: begin
        state_nxt = ST_IDLE;
        clk_d_nxt = 1'b0;
      end
    endcase

    // A parked ratio is applied at a falling toggle or once the divider is
    // (or is about to be) idle. The old flag is used, so a config accepted in
    // the cycle of a falling toggle waits for the next one.
    if (pend && (fall_evt || (state_nxt == ST_IDLE) || (state == ST_IDLE))) begin
      cur_half_nxt = pend_half;
      pend_nxt     = 1'b0;
    end

    if (accept) begin
      if (state == ST_IDLE) begin
        cur_half_nxt = cfg_clamped;
      end else begin
        pend_half_nxt = cfg_clamped;
        pend_nxt      = 1'b1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      clk_d     <= 1'b0;
      tick_rise <= 1'b0;
      tick_fall <= 1'b0;
      cur_half  <= HALF_RST;
      pend      <= 1'b0;
      pend_half <= '0;
      cfg_ready <= 1'b1;
      running   <= 1'b0;
    end else begin
      state     <= state_nxt;
      clk_d     <= clk_d_nxt;
      tick_rise <= tick_rise_nxt;
      tick_fall <= tick_fall_nxt;
      cur_half  <= cur_half_nxt;
      pend      <= pend_nxt;
      pend_half <= pend_half_nxt;
      cfg_ready <= !pend_nxt;
      running   <= (state_nxt != ST_IDLE);
    end
  end

  assign bus.clk_d     = clk_d;
  assign bus.tick_rise = tick_rise;
  assign bus.tick_fall = tick_fall;
  assign bus.cur_half  = cur_half;
  assign bus.cfg_ready = cfg_ready;
  assign bus.running   = running;

endmodule : clk_div_ctrl
`default_nettype wire

// File: tb/tb_clk_div_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_clk_div_ctrl
//  Description : Directed self-checking bench for clk_div_ctrl. Inputs are
//                driven 1 time unit after each rising edge and outputs are
//                sampled at the same point; cycle k is the interval after
//                the k-th edge counted from where run_en was raised.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_clk_div_ctrl;

  logic clk;
  logic rst;

  int n_checks = 0;
  int n_errors = 0;

  clk_div_ctrl_if #(.CNT_W(8)) bus ();

  clk_div_ctrl #(
    .CNT_W        (8),
    .DEFAULT_HALF (2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic e_clk_d, input logic e_rise,
                            input logic e_fall, input logic e_run);
    check({tag, " clk_d"},     32'(bus.clk_d),     32'(e_clk_d));
    check({tag, " tick_rise"}, 32'(bus.tick_rise), 32'(e_rise));
    check({tag, " tick_fall"}, 32'(bus.tick_fall), 32'(e_fall));
    check({tag, " running"},   32'(bus.running),   32'(e_run));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int ph;

    rst           = 1'b0;
    bus.run_en    = 1'b0;
    bus.cfg_valid = 1'b0;
    bus.cfg_half  = '0;

    // ---------------- reset defaults ----------------
    repeat (3) @(posedge clk);
    #1;
    check_outs("rst_hold", 1'b0, 1'b0, 1'b0, 1'b0);
    check("rst_hold cur_half",  32'(bus.cur_half),  32'd2);
    check("rst_hold cfg_ready", 32'(bus.cfg_ready), 32'd1);
    rst = 1'b1;
    step();
    check_outs("rst_rel", 1'b0, 1'b0, 1'b0, 1'b0);
    check("rst_rel cur_half",  32'(bus.cur_half),  32'd2);
    check("rst_rel cfg_ready", 32'(bus.cfg_ready), 32'd1);

    // ---------------- default divide-by-4 ----------------
    bus.run_en = 1'b1;
    for (int k = 1; k <= 15; k++) begin
      step();
      if (k < 3) begin
        check_outs($sformatf("dflt c%0d", k), 1'b0, 1'b0, 1'b0, 1'b1);
      end else begin
        ph = (k - 3) % 4;
        check_outs($sformatf("dflt c%0d", k), ph < 2, ph == 0, ph == 2, 1'b1);
      end
    end

    // ---------------- mid-run reconfig to H=5 (cycle 15 is a rise) ----------------
    bus.cfg_valid = 1'b1;
    bus.cfg_half  = 8'd5;
    step();
    bus.cfg_valid = 1'b0;
    check("recfg c16 cfg_ready", 32'(bus.cfg_ready), 32'd0);
    check("recfg c16 cur_half",  32'(bus.cur_half),  32'd2);
    check_outs("recfg c16", 1'b1, 1'b0, 1'b0, 1'b1);
    for (int k = 17; k <= 32; k++) begin
      step();
      ph = (k - 17) % 10;
      check_outs($sformatf("recfg c%0d", k), ph >= 5, ph == 5, ph == 0, 1'b1);
      check($sformatf("recfg c%0d cur_half", k),  32'(bus.cur_half),  32'd5);
      check($sformatf("recfg c%0d cfg_ready", k), 32'(bus.cfg_ready), 32'd1);
    end

    // ---------------- stop during high phase (H=5), cycle 32 is a rise ----------------
    bus.run_en = 1'b0;
    for (int k = 33; k <= 40; k++) begin
      step();
      check_outs($sformatf("stop5 c%0d", k), k <= 36, 1'b0, k == 37, k <= 36);
    end

    // ---------------- idle config H=3 ----------------
    bus.cfg_valid = 1'b1;
    bus.cfg_half  = 8'd3;
    step();
    bus.cfg_valid = 1'b0;
    check("cfg3 cur_half",  32'(bus.cur_half),  32'd3);
    check("cfg3 cfg_ready", 32'(bus.cfg_ready), 32'd1);
    check("cfg3 running",   32'(bus.running),   32'd0);

    // ---------------- H=3 run with a short stop/resume inside the high phase ----------------
    bus.run_en = 1'b1;
    for (int r = 1; r <= 16; r++) begin
      step();
      if (r < 4) begin
        check_outs($sformatf("h3 r%0d", r), 1'b0, 1'b0, 1'b0, 1'b1);
      end else begin
        ph = (r - 4) % 6;
        check_outs($sformatf("h3 r%0d", r), ph < 3, ph == 0, ph == 3, 1'b1);
      end
      if (r == 4) bus.run_en = 1'b0;
      if (r == 5) bus.run_en = 1'b1;
    end

    // ---------------- clean stop H=3 (r16 is a rise) ----------------
    bus.run_en = 1'b0;
    for (int r = 17; r <= 21; r++) begin
      step();
      check_outs($sformatf("stop3 r%0d", r), r < 19, 1'b0, r == 19, r < 19);
    end

    // ---------------- zero config -> H=1 ----------------
    bus.cfg_valid = 1'b1;
    bus.cfg_half  = 8'd0;
    step();
    bus.cfg_valid = 1'b0;
    check("zero cur_half",  32'(bus.cur_half),  32'd1);
    check("zero cfg_ready", 32'(bus.cfg_ready), 32'd1);
    bus.run_en = 1'b1;
    for (int s = 1; s <= 8; s++) begin
      step();
      check_outs($sformatf("h1 s%0d", s), (s >= 2) && (s % 2 == 0),
                 (s >= 2) && (s % 2 == 0), (s >= 3) && (s % 2 == 1), 1'b1);
    end

    // s8 is a high cycle that wraps: this config coincides with a falling toggle
    bus.cfg_valid = 1'b1;
    bus.cfg_half  = 8'd7;
    step();
    bus.cfg_valid = 1'b0;
    check("coinc cfg_ready", 32'(bus.cfg_ready), 32'd0);
    check("coinc cur_half",  32'(bus.cur_half),  32'd1);
    check_outs("coinc", 1'b0, 1'b0, 1'b1, 1'b1);

    // ---------------- reset mid-operation with a config pending ----------------
    rst = 1'b0;
    #2;
    check_outs("midrst", 1'b0, 1'b0, 1'b0, 1'b0);
    check("midrst cur_half",  32'(bus.cur_half),  32'd2);
    check("midrst cfg_ready", 32'(bus.cfg_ready), 32'd1);
    bus.run_en = 1'b0;
    repeat (2) step();
    rst = 1'b1;
    step();
    check("postrst cur_half",  32'(bus.cur_half),  32'd2);
    check("postrst cfg_ready", 32'(bus.cfg_ready), 32'd1);
    check("postrst running",   32'(bus.running),   32'd0);
    bus.run_en = 1'b1;
    for (int u = 1; u <= 8; u++) begin
      step();
      if (u < 3) begin
        check_outs($sformatf("postrst u%0d", u), 1'b0, 1'b0, 1'b0, 1'b1);
      end else begin
        ph = (u - 3) % 4;
        check_outs($sformatf("postrst u%0d", u), ph < 2, ph == 0, ph == 2, 1'b1);
      end
      check($sformatf("postrst u%0d cur_half", u), 32'(bus.cur_half), 32'd2);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_clk_div_ctrl
`default_nettype wire

// File: doc/clk_div_ctrl.md
# clk_div_ctrl

Programmable clock-divider controller that produces a divided clock level and aligned edge strobes from the system clock. Half-period length is run-time configurable over a valid/ready handshake, and start/stop is controlled by an enable. New ratios and stops take effect only at period boundaries, so `clk_d` never produces a runt pulse. It sits between the control registers and every block that consumes a slow clock or clock-enable.

## Interface
Parameters:
- `CNT_W`, default 8: width of the half-period count and counter.
- `DEFAULT_HALF`, default 2: half-period (in `clk` cycles) loaded at reset. A value of 2 gives divide-by-4.

Ports:
- `clk`  in  1  system clock; all logic on the rising edge.
- `rst`  in  1  asynchronous reset, **active-low**. Assertion is asynchronous; the reset value applies while `rst`=0.
- `run_en`  in  1  level request to run the divider.
- `cfg_valid`  in  1  new half-period offered.
- `cfg_half`  in  `CNT_W`  offered half-period. 0 is accepted and stored as 1.
- `cfg_ready`  out  1  controller can accept a config.
- `clk_d`  out  1  divided clock level; period 2×H cycles.
- `tick_rise`  out  1  one-cycle pulse, high in the first cycle `clk_d` reads 1.
- `tick_fall`  out  1  one-cycle pulse, high in the first cycle `clk_d` reads 0 after a high phase.
- `cur_half`  out  `CNT_W`  half-period H currently in effect.
- `running`  out  1  high in the RUN and STOP states.

## Operation
- States: IDLE, RUN, STOP.
- **IDLE**
  - Counter is 0 and `clk_d` is 0.
  - If `run_en`=1, go to RUN; counting starts the next cycle.
- **RUN**
  - The counter increments every cycle.
  - When counter == H−1: counter ← 0, `clk_d` toggles, and the matching tick pulses.
- **Stopping from RUN** (`run_en`=0):
  - If `clk_d`=0, go to IDLE next cycle and clear the counter.
  - If `clk_d`=1, go to STOP.
- **STOP**
  - Counting continues until the falling toggle, then go to IDLE.
  - If `run_en` returns to 1 while in STOP, go back to RUN with no disturbance to the count.
- **Config handshake**
  - A transfer occurs when `cfg_valid` && `cfg_ready`.
  - In IDLE: `cur_half` is updated the next cycle.
  - In RUN or STOP: the value is held in a pending register, a pending flag is set, and `cfg_ready` drops.
  - The pending value loads into `cur_half` in the cycle of the next falling toggle, so the full period in progress completes with the old H. The pending flag clears in the same cycle and `cfg_ready` rises the next cycle.
  - `cfg_ready` = !pending.
  - If a pending value exists when the block enters IDLE, it is applied on that entry.
- **Arithmetic**
  - The counter is `CNT_W` bits and is compared against H−1.
  - H ≥ 1 always, so no wrap beyond H−1 is possible.
  - H=1 gives `clk_d` = clk/2.
- **Simultaneous events**
  - A config accepted in the same cycle as a falling toggle is **not** applied at that toggle; it waits for the next falling toggle.
  - A `run_en` drop coinciding with a falling toggle goes to IDLE.

## Timing
- **Reset values:** state IDLE, counter 0, `clk_d`=0, `tick_rise`=0, `tick_fall`=0, `cur_half`=`DEFAULT_HALF` (clamped to ≥1), pending=0, `cfg_ready`=1, `running`=0.
- **Start latency:** `run_en` sampled high in cycle t (IDLE) → `running`=1 at t+1 → first `tick_rise` / `clk_d`=1 at t+1+H.
- **Registered outputs:** all outputs are registered. Each tick is coincident with the new `clk_d` level.
- **Reset mid-operation:** all outputs return to reset values asynchronously, and a pending config is discarded.

## Structure
- Package `clk_div_pkg` holds:
  - the state enum `div_state_t` (IDLE, RUN, STOP);
  - the default `CNT_W` constant;
  - a `clamp_half()` function (maps 0 to 1).
- One sub-module, `clk_div_counter`: a loadable counter that asserts `wrap` at H−1. The FSM, the config pending register and the toggle logic stay in `clk_div_ctrl`.

## Test plan
- **Reset defaults:** hold `rst`=0, then release with `run_en`=0 → all outputs at reset values; `cur_half`=2; `cfg_ready`=1.
- **Default divide:** `run_en`=1 from cycle 0 → `clk_d` has period 4 (2 high / 2 low); `tick_rise` and `tick_fall` each pulse once per 4 cycles; first rise at cycle 3.
- **Mid-run reconfig:** while running with H=2, send `cfg_half`=5 mid-high-phase → `cfg_ready` drops; the current period finishes at 4 cycles; `cur_half`=5 from the falling toggle; following periods are 10 cycles; `cfg_ready` returns 1 the cycle after.
- **Clean stop:** drop `run_en` while `clk_d`=1 with H=3 → the high phase still lasts 3 cycles; `tick_fall` fires; state IDLE; `clk_d` stays 0. Re-raise `run_en` inside STOP → no gap in periodicity.
- **Zero config:** in IDLE, `cfg_half`=0 → `cur_half`=1; after `run_en`=1, `clk_d` toggles every cycle.
- **Reset mid-operation:** assert `rst` while running with a config pending → immediate reset values; after release, `cur_half`=`DEFAULT_HALF` and the pending value is lost.
